// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, coordinate type and sync bundle shared by
// the timing generator, its interface and the sync delay line.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  // Region boundaries as 10-bit values; *_END bounds are exclusive
  localparam coord_t H_VIS_END    = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_BEGIN = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t H_WRAP       = coord_t'(H_TOTAL);
  localparam coord_t V_VIS_END    = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_BEGIN = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
  localparam coord_t V_WRAP       = coord_t'(V_TOTAL);

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position, sync and frame/line markers from the timing generator.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
();
  coord_t DrawX;
  coord_t DrawY;
  logic   hs;
  logic   vs;
  logic   blank;
  logic   frame_start;
  logic   line_start;

  modport master (output DrawX, DrawY, hs, vs, blank, frame_start, line_start);
  modport slave  (input  DrawX, DrawY, hs, vs, blank, frame_start, line_start);
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth pipeline for the hs/vs/blank bundle; stages reset to idle so the
// outputs stay idle for DEPTH cycles after reset release.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  sync_t din,
  output sync_t dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      sync_t stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with sync/blank decode; sync outputs lag the
// counters by SYNC_DELAY cycles to match a downstream pixel pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  coord_t hc;
  coord_t vc;
  coord_t hc_inc_c;
  coord_t vc_inc_c;
  logic   h_wrap_c;
  logic   v_wrap_c;
  sync_t  raw_c;
  sync_t  sync_d;

  // Increments stay within 10 bits since the wrap values are at most 800
  assign hc_inc_c = hc + coord_t'(1);
  assign vc_inc_c = vc + coord_t'(1);
  assign h_wrap_c = (hc_inc_c == H_WRAP);
  assign v_wrap_c = (vc_inc_c == V_WRAP);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= h_wrap_c ? '0 : hc_inc_c;
      if (h_wrap_c) vc <= v_wrap_c ? '0 : vc_inc_c;
    end
  end

  // Blank is gated by reset so the zero-depth path is idle while reset is held
  always_comb begin
    raw_c       = SYNC_IDLE;
    raw_c.hs    = !in_range(hc, H_SYNC_BEGIN, H_SYNC_END);
    raw_c.vs    = !in_range(vc, V_SYNC_BEGIN, V_SYNC_END);
    raw_c.blank = (hc < H_VIS_END) && (vc < V_VIS_END) && !reset;
  end

  sync_delay_line #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk  (vga_clk),
    .rst  (reset),
    .din  (raw_c),
    .dout (sync_d)
  );

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.hs          = sync_d.hs;
  assign vga.vs          = sync_d.vs;
  assign vga.blank       = sync_d.blank;
  assign vga.line_start  = !reset && (hc == '0);
  assign vga.frame_start = !reset && (hc == '0) && (vc == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with SYNC_DELAY=0 and SYNC_DELAY=2 side by side.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if v0 ();
  vga_timing_gen_if v2 ();

  vga_timing_gen #(.SYNC_DELAY(0)) dut0 (.vga_clk(clk), .reset(rst), .vga(v0));
  vga_timing_gen #(.SYNC_DELAY(2)) dut2 (.vga_clk(clk), .reset(rst), .vga(v2));

  localparam logic [2:0] IDLE = 3'b110;

  int checks   = 0;
  int failures = 0;
  int mh, mv;
  logic [2:0] p0, p1;
  logic [9:0] jh, jv;
  int ls_cnt, fs_cnt, bl_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {hs, vs, blank} from hand-written VGA 640x480 boundaries
  function automatic logic [2:0] raw(input int h, input int v);
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491), (h < 640 && v < 480)};
  endfunction

  task automatic check_all(input string tag);
    logic fs, ls;
    fs = (mh == 0 && mv == 0);
    ls = (mh == 0);
    check(tag,
      64'({v0.DrawX, v0.DrawY, v2.DrawX, v2.DrawY,
           v0.frame_start, v0.line_start, v2.frame_start, v2.line_start,
           v0.hs, v0.vs, v0.blank, v2.hs, v2.vs, v2.blank}),
      64'({10'(mh), 10'(mv), 10'(mh), 10'(mv), fs, ls, fs, ls, raw(mh, mv), p1}));
  endtask

  task automatic step();
    p1 = p0;
    p0 = raw(mh, mv);
    mh++;
    if (mh == 800) begin
      mh = 0;
      mv++;
      if (mv == 525) mv = 0;
    end
    @(posedge clk);
    #1;
    if (v0.line_start) ls_cnt++;
    if (v0.frame_start) fs_cnt++;
    if (v2.blank) bl_cnt++;
    check_all("cycle");
  endtask

  task automatic jump(input int h, input int v);
    jh = 10'(h);
    jv = 10'(v);
    force dut0.hc = jh;
    force dut0.vc = jv;
    force dut2.hc = jh;
    force dut2.vc = jv;
    #1;
    release dut0.hc;
    release dut0.vc;
    release dut2.hc;
    release dut2.vc;
    mh = h;
    mv = v;
  endtask

  task automatic clear_counts();
    ls_cnt = 0;
    fs_cnt = 0;
    bl_cnt = 0;
  endtask

  initial begin
    mh = 0; mv = 0; p0 = IDLE; p1 = IDLE;
    clear_counts();

    repeat (3) @(posedge clk);
    #1;
    check("rst_x0",     64'(v0.DrawX), 64'd0);
    check("rst_y2",     64'(v2.DrawY), 64'd0);
    check("rst_sync2",  64'({v2.hs, v2.vs, v2.blank}), 64'(IDLE));
    check("rst_blank0", 64'(v0.blank), 64'd0);
    check("rst_fs_ls",  64'({v0.frame_start, v0.line_start, v2.frame_start}), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("t0");
    check("t0_fs2",     64'(v2.frame_start), 64'd1);
    check("t0_blank2",  64'(v2.blank), 64'd0);
    check("t0_blank0",  64'(v0.blank), 64'd1);

    // Lines 0 and 1 with horizontal boundary spot checks
    for (int t = 1; t <= 1600; t++) begin
      step();
      if (mv == 0) begin
        if (mh == 1)   check("x1_blank2", 64'({v2.blank, v0.DrawX}), 64'({1'b0, 10'd1}));
        if (mh == 2)   check("x2_blank2_rise", 64'(v2.blank), 64'd1);
        if (mh == 641) check("x641_blank2", 64'(v2.blank), 64'd1);
        if (mh == 642) check("x642_blank2_fall", 64'(v2.blank), 64'd0);
        if (mh == 655) check("hs0_655", 64'(v0.hs), 64'd1);
        if (mh == 656) check("hs0_656", 64'(v0.hs), 64'd0);
        if (mh == 751) check("hs0_751", 64'(v0.hs), 64'd0);
        if (mh == 752) check("hs0_752", 64'(v0.hs), 64'd1);
      end
      if (mv == 1 && mh == 0)
        check("line1_start", 64'({v0.line_start, v0.frame_start, v2.DrawY}), 64'({2'b10, 10'd1}));
    end
    check("a_ls_cnt", 64'(ls_cnt), 64'd2);
    check("a_fs_cnt", 64'(fs_cnt), 64'd0);
    check("a_bl_cnt", 64'(bl_cnt), 64'd1280);

    // Bottom of frame through the frame wrap
    jump(790, 488);
    check_all("jump_b");
    clear_counts();
    for (int i = 0; i < 28810; i++) begin
      step();
      if (mh == 0 && mv == 489) check("vs0_489", 64'(v0.vs), 64'd1);
      if (mh == 0 && mv == 490) check("vs0_490", 64'(v0.vs), 64'd0);
      if (mh == 0 && mv == 491) check("vs0_491", 64'(v0.vs), 64'd0);
      if (mh == 0 && mv == 492) check("vs0_492", 64'(v0.vs), 64'd1);
      if (mh == 799 && mv == 524)
        check("last_px", 64'({v2.DrawX, v2.DrawY}), 64'({10'd799, 10'd524}));
    end
    check("wrap", 64'({v0.DrawX, v0.DrawY, v2.frame_start, v2.line_start}),
          64'({10'd0, 10'd0, 2'b11}));
    check("b_ls_cnt", 64'(ls_cnt), 64'd37);
    check("b_fs_cnt", 64'(fs_cnt), 64'd1);
    check("b_bl_cnt", 64'(bl_cnt), 64'd0);
    step();
    check("f1_blank2", 64'(v2.blank), 64'd0);
    step();
    check("f2_blank2_rise", 64'(v2.blank), 64'd1);

    // Asynchronous reset mid-frame
    jump(290, 200);
    repeat (10) step();
    check("pre_rst_pos", 64'({v2.DrawX, v2.DrawY}), 64'({10'd300, 10'd200}));
    #2;
    rst = 1'b1;
    #1;
    check("arst_pos",   64'({v0.DrawX, v0.DrawY, v2.DrawX, v2.DrawY}), 64'd0);
    check("arst_sync0", 64'({v0.hs, v0.vs, v0.blank}), 64'(IDLE));
    check("arst_sync2", 64'({v2.hs, v2.vs, v2.blank}), 64'(IDLE));
    check("arst_fs",    64'({v0.frame_start, v2.line_start}), 64'd0);
    @(posedge clk);
    #1;
    check("arst_hold",  64'({v2.DrawX, v2.blank}), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    mh = 0; mv = 0; p0 = IDLE; p1 = IDLE;
    #1;
    check_all("rel_t0");
    check("rel_fs", 64'(v2.frame_start), 64'd1);
    step();
    check("rel_t1", 64'({v2.DrawX, v2.blank, v2.frame_start}), 64'({10'd1, 2'b00}));
    step();
    check("rel_t2_blank2", 64'(v2.blank), 64'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter SYNC_DELAY, default 2, is the number of vga_clk stages by which hs, vs and blank lag DrawX/DrawY; legal range 0..4.
REQ-002 Port vga_clk  input  1  pixel clock, 25 MHz nominal; the only clock.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port DrawX  output  10  current horizontal pixel counter, 0..799.
REQ-005 Port DrawY  output  10  current vertical line counter, 0..524.
REQ-006 Port hs  output  1  horizontal sync, active-low, delayed by SYNC_DELAY.
REQ-007 Port vs  output  1  vertical sync, active-low, delayed by SYNC_DELAY.
REQ-008 Port blank  output  1  display enable, 1 = visible pixel, delayed by SYNC_DELAY.
REQ-009 Port frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0; not delayed.
REQ-010 Port line_start  output  1  one-cycle pulse when DrawX==0; not delayed.

Function
REQ-011 The horizontal counter hc SHALL increment by 1 every vga_clk cycle and wrap 799->0.
REQ-012 The vertical counter vc SHALL increment by 1 only in the cycle where hc wraps 799->0, and SHALL wrap 524->0 in the same cycle that hc wraps with vc==524.
REQ-013 DrawX SHALL equal hc and DrawY SHALL equal vc, driven directly from the counter registers.
REQ-014 Horizontal regions: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-015 Vertical regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-016 Undelayed hs_raw SHALL be 0 exactly when hc is in 656..751, else 1; vs_raw SHALL be 0 exactly when vc is in 490..491, else 1.
REQ-017 Undelayed blank_raw SHALL be 1 exactly when hc<640 and vc<480.
REQ-018 hs, vs and blank SHALL equal hs_raw, vs_raw and blank_raw from SYNC_DELAY cycles earlier; with SYNC_DELAY=0 they are combinational from the counters.
REQ-019 With SYNC_DELAY=2, a consumer that presents DrawX/DrawY to a 1-cycle ROM followed by a 1-cycle colour register SHALL see blank aligned to the colour for that pixel.
REQ-020 Frame timing SHALL be exactly 800 x 525 = 420000 cycles, with no dropped or duplicated counts at either wrap.
REQ-021 Counter comparisons SHALL use 10-bit unsigned arithmetic; no intermediate value exceeds 10 bits.

Reset
REQ-022 While reset=1: hc=0, vc=0, every delay stage holds idle values (hs=1, vs=1, blank=0), frame_start=0, line_start=0.
REQ-023 Assertion of reset mid-frame SHALL force the REQ-022 values immediately, without waiting for a clock edge.
REQ-024 In the first vga_clk edge after reset deasserts, hc SHALL advance 0->1; DrawX=0 and DrawY=0 SHALL be presented for exactly one cycle after deassertion, and frame_start SHALL be 1 during that cycle.
REQ-025 After deassertion, hs, vs and blank SHALL keep their idle values for SYNC_DELAY cycles before reflecting counter state.

Structure
REQ-026 Package vga_timing_pkg SHALL hold H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33 and V_TOTAL=525, plus the 10-bit coordinate typedef.
REQ-027 Region boundaries SHALL be derived from the package constants only, with no literal numbers in the RTL.
REQ-028 One sub-module, sync_delay_line, SHALL implement the parameterised 3-bit delay with reset-to-idle values.

Verification
REQ-029 Release reset, run 420000 cycles -> DrawX/DrawY sweep 0..799/0..524 once each, and frame_start pulses exactly twice (cycle 0 and cycle 420000).
REQ-030 SYNC_DELAY=0: check hs at DrawX=655/656/751/752 -> 1/0/0/1; check vs at DrawY=489/490/491/492 -> 1/0/0/1.
REQ-031 SYNC_DELAY=2: blank rises 2 cycles after DrawX=0,DrawY=0 and falls 2 cycles after DrawX=640; blank=0 throughout DrawY=480..524.
REQ-032 At hc=799, vc=524 -> next cycle DrawX=0, DrawY=0, frame_start=1, line_start=1.
REQ-033 Assert reset asynchronously at DrawX=300, DrawY=200 -> before the next edge DrawX=0, DrawY=0, hs=1, vs=1, blank=0; after release, the timing restarts per REQ-024/025.
REQ-034 Count line_start pulses per frame -> 525; count blank=1 cycles per frame -> 307200.
